// File: rtl/ttl_counter_pseudo_edge.sv
// 74LS161/163-style synchronous binary counter clocked by a sampled pseudo-clock (cen).
// Optional up/down counting is enabled with the TTL_COUNTER_UPDOWN_EN macro.
module ttl_counter_pseudo_edge #(
  parameter int unsigned W        = 4,
  parameter int unsigned SYNC_CLR = 0,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen,
  input  logic         clr_n,
  input  logic         load_n,
  input  logic         enp,
  input  logic         ent,
`ifdef TTL_COUNTER_UPDOWN_EN
  input  logic         dn,
`endif
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         rco,
  output logic         tc_pulse
);

  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  logic         last_cen;
  logic         edge_c;
  logic         clear_c;
  logic         load_c;
  logic         count_c;
  logic         down_c;
  logic         term_c;
  logic [W-1:0] q_nxt;
  logic         tc_nxt;

`ifdef TTL_COUNTER_UPDOWN_EN
  assign down_c = dn;
`else
  assign down_c = 1'b0;
`endif

  // Rising edge of the pseudo-clock; last_cen resets high so a held cen is not an edge.
  assign edge_c  = cen & ~last_cen;
  assign clear_c = (SYNC_CLR != 0) ? (edge_c & ~clr_n) : ~clr_n;
  assign load_c  = edge_c & ~load_n & ~clear_c;
  assign count_c = edge_c & load_n & enp & ent & ~clear_c;
  assign term_c  = down_c ? (q == '0) : (q == ALL_ONES);
  assign rco     = ent & term_c;

  // Priority: clear, load, count, hold.
  always_comb begin
    q_nxt  = q;
    tc_nxt = 1'b0;
    if (clear_c) begin
      q_nxt = '0;
    end else if (load_c) begin
      q_nxt = d;
    end else if (count_c) begin
      q_nxt  = down_c ? (q - W'(1)) : (q + W'(1));
      tc_nxt = term_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= W'(RST_VAL);
      last_cen <= 1'b1;
      tc_pulse <= 1'b0;
    end else begin
      q        <= q_nxt;
      last_cen <= cen;
      tc_pulse <= tc_nxt;
    end
  end

endmodule

// File: tb/tb_ttl_counter_pseudo_edge.sv
// Bench for ttl_counter_pseudo_edge: '161 and '163 instances share stimulus, plus a two-stage cascade.
module tb_ttl_counter_pseudo_edge;

  localparam int unsigned W = 4;
  localparam int LIM = 16;

  logic clk = 1'b0;
  logic rst_n, cen, clr_n, load_n, enp, ent, dn;
  logic [W-1:0] d;
  logic cen_c, enp_c;

  logic [W-1:0] qa, qb, q1, q2;
  logic rco_a, rco_b, rco1, rco2, tc_a, tc_b, tc1, tc2;

  int vectors = 0;
  int miscompares = 0;
  int tc_seen = 0;

  int mq_a = 0, mtc_a = 0, mq_b = 0, mtc_b = 0, mc = 0;
  bit mlast = 1'b1, mlast_c = 1'b1;

  always #5 clk = ~clk;

  ttl_counter_pseudo_edge #(.W(W), .SYNC_CLR(0), .RST_VAL(0)) u_a (
    .clk(clk), .rst_n(rst_n), .cen(cen), .clr_n(clr_n), .load_n(load_n),
    .enp(enp), .ent(ent),
`ifdef TTL_COUNTER_UPDOWN_EN
    .dn(dn),
`endif
    .d(d), .q(qa), .rco(rco_a), .tc_pulse(tc_a));

  ttl_counter_pseudo_edge #(.W(W), .SYNC_CLR(1), .RST_VAL(0)) u_b (
    .clk(clk), .rst_n(rst_n), .cen(cen), .clr_n(clr_n), .load_n(load_n),
    .enp(enp), .ent(ent),
`ifdef TTL_COUNTER_UPDOWN_EN
    .dn(dn),
`endif
    .d(d), .q(qb), .rco(rco_b), .tc_pulse(tc_b));

  ttl_counter_pseudo_edge #(.W(W), .SYNC_CLR(0), .RST_VAL(0)) u_c1 (
    .clk(clk), .rst_n(rst_n), .cen(cen_c), .clr_n(1'b1), .load_n(1'b1),
    .enp(enp_c), .ent(1'b1),
`ifdef TTL_COUNTER_UPDOWN_EN
    .dn(1'b0),
`endif
    .d(4'h0), .q(q1), .rco(rco1), .tc_pulse(tc1));

  ttl_counter_pseudo_edge #(.W(W), .SYNC_CLR(0), .RST_VAL(0)) u_c2 (
    .clk(clk), .rst_n(rst_n), .cen(cen_c), .clr_n(1'b1), .load_n(1'b1),
    .enp(enp_c), .ent(rco1),
`ifdef TTL_COUNTER_UPDOWN_EN
    .dn(1'b0),
`endif
    .d(4'h0), .q(q2), .rco(rco2), .tc_pulse(tc2));

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one counter for one clk, from the TTL rules.
  function automatic void step(input bit sync, input bit pe, inout int mq, inout int mtc);
    if ((!sync && !clr_n) || (sync && pe && !clr_n)) begin
      mq = 0; mtc = 0;
    end else if (pe && !load_n) begin
      mq = int'(d); mtc = 0;
    end else if (pe && enp && ent) begin
      if (dn) begin
        mtc = (mq == 0) ? 1 : 0;
        mq  = (mq + LIM - 1) % LIM;
      end else begin
        mtc = (mq == LIM - 1) ? 1 : 0;
        mq  = (mq + 1) % LIM;
      end
    end else begin
      mtc = 0;
    end
  endfunction

  function automatic int exp_rco(input int mq);
    if (!ent) return 0;
    if (dn) return (mq == 0) ? 1 : 0;
    return (mq == LIM - 1) ? 1 : 0;
  endfunction

  task automatic cycle();
    bit pe, pec;
    @(posedge clk);
    if (!rst_n) begin
      mq_a = 0; mtc_a = 0; mq_b = 0; mtc_b = 0; mc = 0;
      mlast = 1'b1; mlast_c = 1'b1;
    end else begin
      pe = cen && !mlast;
      mlast = cen;
      step(1'b0, pe, mq_a, mtc_a);
      step(1'b1, pe, mq_b, mtc_b);
      pec = cen_c && !mlast_c;
      mlast_c = cen_c;
      if (pec && enp_c) mc = (mc + 1) % 256;
    end
    #1;
    check("q_a", int'(qa), mq_a);
    check("rco_a", int'(rco_a), exp_rco(mq_a));
    check("tc_a", int'(tc_a), mtc_a);
    check("q_b", int'(qb), mq_b);
    check("rco_b", int'(rco_b), exp_rco(mq_b));
    check("tc_b", int'(tc_b), mtc_b);
    check("casc_q", int'({q2, q1}), mc);
    check("casc_rco", int'(rco2), (mc == 255) ? 1 : 0);
    if (tc_a) tc_seen++;
  endtask

  initial begin
    rst_n = 1'b1; cen = 1'b1; clr_n = 1'b1; load_n = 1'b1;
    enp = 1'b1; ent = 1'b1; dn = 1'b0; d = '0;
    cen_c = 1'b1; enp_c = 1'b1;
    #2 rst_n = 1'b0;
    cycle(); cycle();
    check("rst_q", int'(qa), 0);
    check("rst_tc", int'(tc_a), 0);

    // cen held high across reset release must not count
    rst_n = 1'b1;
    repeat (5) cycle();
    check("held_cen_q", int'(qa), 0);
    check("held_cen_casc", int'({q2, q1}), 0);

    // 20 single-clk pulses: one wrap
    cen = 1'b0; cen_c = 1'b0;
    cycle();
    tc_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cen = 1'b1; cycle();
      cen = 1'b0; cycle();
    end
    check("pulse20_q", int'(qa), 4);
    check("pulse20_tc_count", tc_seen, 1);

    // load, then load colliding with clear
    load_n = 1'b0; d = 4'hA; cen = 1'b1; cycle();
    check("load_q", int'(qa), 10);
    check("load_tc", int'(tc_a), 0);
    cen = 1'b0; cycle();
    clr_n = 1'b0; cen = 1'b1; cycle();
    check("clr_wins_a", int'(qa), 0);
    check("clr_wins_b", int'(qb), 0);
    clr_n = 1'b1; cen = 1'b0; cycle();

    // clear without edge: '161 clears, '163 holds until the next edge
    d = 4'h5; cen = 1'b1; cycle();
    load_n = 1'b1; cen = 1'b0; cycle();
    clr_n = 1'b0; cycle();
    check("async_clr_a", int'(qa), 0);
    check("sync_clr_hold_b", int'(qb), 5);
    clr_n = 1'b1; cycle();
    check("sync_clr_still_b", int'(qb), 5);
    clr_n = 1'b0; cen = 1'b1; cycle();
    check("sync_clr_edge_b", int'(qb), 0);
    clr_n = 1'b1; cen = 1'b0; cycle();

    // cascade: 256 edges wrap the 8-bit count, then enp=0 holds both stages
    for (int i = 0; i < 256; i++) begin
      cen_c = 1'b1; cycle();
      cen_c = 1'b0; cycle();
    end
    check("casc_wrap", int'({q2, q1}), 0);
    for (int i = 0; i < 21; i++) begin
      cen_c = 1'b1; cycle();
      cen_c = 1'b0; cycle();
    end
    check("casc_21", int'({q2, q1}), 21);
    enp_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cen_c = 1'b1; cycle();
      cen_c = 1'b0; cycle();
    end
    check("casc_hold", int'({q2, q1}), 21);
    enp_c = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cen    = 1'($urandom_range(0, 1));
      clr_n  = ($urandom_range(0, 15) != 0);
      load_n = ($urandom_range(0, 7) != 0);
      enp    = ($urandom_range(0, 3) != 0);
      ent    = ($urandom_range(0, 3) != 0);
      d      = W'($urandom);
      cen_c  = 1'($urandom_range(0, 1));
      enp_c  = ($urandom_range(0, 3) != 0);
`ifdef TTL_COUNTER_UPDOWN_EN
      dn     = 1'($urandom_range(0, 1));
`endif
      cycle();
    end
    cen = 1'b0; clr_n = 1'b1; load_n = 1'b1; enp = 1'b1; ent = 1'b1; cen_c = 1'b0;
    dn = 1'b0;
    cycle();

`ifdef TTL_COUNTER_UPDOWN_EN
    // down count through zero
    dn = 1'b1; load_n = 1'b0; d = 4'h1; cen = 1'b1; cycle();
    check("dn_load", int'(qa), 1);
    load_n = 1'b1; cen = 1'b0; cycle();
    cen = 1'b1; cycle();
    check("dn_q0", int'(qa), 0);
    check("dn_rco0", int'(rco_a), 1);
    cen = 1'b0; cycle();
    cen = 1'b1; cycle();
    check("dn_q15", int'(qa), 15);
    check("dn_tc", int'(tc_a), 1);
    cen = 1'b0; cycle();
    check("dn_tc_clear", int'(tc_a), 0);
    dn = 1'b0; cycle();
`endif

    // async reset mid-count resumes from RST_VAL
    cen = 1'b1; cycle();
    #2 rst_n = 1'b0;
    #1 check("async_rst_q", int'(qa), 0);
    cycle();
    rst_n = 1'b1; cen = 1'b0; cycle();
    cen = 1'b1; cycle();
    check("post_rst_count", int'(qa), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
